// File: rtl/spi_reg_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// spi_reg_pkg : shared encodings for the SPI register-access arbiter
// Revision    : 1.0
// ============================================================================
package spi_reg_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND_CMD  = 3'd1;
    localparam logic [2:0] ST_GUARD     = 3'd2;
    localparam logic [2:0] ST_SEND_DATA = 3'd3;
    localparam logic [2:0] ST_WAIT_RX   = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    localparam int         BYTES_PER_XFER = 2;
    localparam logic [7:0] READ_DUMMY     = 8'h00;

    // Command byte: bit 7 carries the read/write polarity, bits 6:0 the address.
    function automatic logic [7:0] cmd_byte(input logic       rw,
                                            input logic       read_pol,
                                            input logic [6:0] addr);
        return {(rw ? read_pol : ~read_pol), addr};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_reg_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// spi_reg_access_arbiter_if : requester bus plus SPI-wrapper byte interface
// Revision                  : 1.0
// ============================================================================
interface spi_reg_access_arbiter_if #(
    parameter int NUM_REQ = 2
) ();

    logic [NUM_REQ-1:0]   i_Req_Valid;
    logic [NUM_REQ-1:0]   i_Req_RW;
    logic [7*NUM_REQ-1:0] i_Req_Addr;
    logic [8*NUM_REQ-1:0] i_Req_WData;
    logic [NUM_REQ-1:0]   o_Req_Ready;
    logic [NUM_REQ-1:0]   o_Rsp_Valid;
    logic [7:0]           o_Rsp_RData;
    logic                 o_Busy;

    logic [1:0]           o_TX_Count;
    logic [7:0]           o_TX_Byte;
    logic                 o_TX_DV;
    logic                 i_TX_Ready;
    logic                 i_RX_DV;
    logic [7:0]           i_RX_Byte;
    logic [1:0]           i_RX_Count;

    // Arbiter view
    modport slave (
        input  i_Req_Valid, i_Req_RW, i_Req_Addr, i_Req_WData,
        input  i_TX_Ready, i_RX_DV, i_RX_Byte, i_RX_Count,
        output o_Req_Ready, o_Rsp_Valid, o_Rsp_RData, o_Busy,
        output o_TX_Count, o_TX_Byte, o_TX_DV
    );

    // Requesters plus SPI wrapper view
    modport master (
        output i_Req_Valid, i_Req_RW, i_Req_Addr, i_Req_WData,
        output i_TX_Ready, i_RX_DV, i_RX_Byte, i_RX_Count,
        input  o_Req_Ready, o_Rsp_Valid, o_Rsp_RData, o_Busy,
        input  o_TX_Count, o_TX_Byte, o_TX_DV
    );

endinterface
`default_nettype wire

// File: rtl/spi_reg_access_arbiter_rr.sv
`default_nettype none
// ============================================================================
// spi_rr_arbiter : combinational round-robin grant, searching up from ptr+1
// Revision       : 1.0
// ============================================================================
module spi_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_reg_access_arbiter.sv
`default_nettype none
// ============================================================================
// spi_reg_access_arbiter : serialises register reads/writes from NUM_REQ
//                          requesters into 2-byte CS-framed SPI transactions
// Revision               : 1.0
// ============================================================================
module spi_reg_access_arbiter
    import spi_reg_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter bit READ_POL = 1'b1
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    spi_reg_access_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [2:0]         state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic               cur_rw;
    logic [6:0]         cur_addr;
    logic [7:0]         cur_wdata;
    logic [7:0]         rx_data;

    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [7:0]         rsp_rdata;
    logic               busy;
    logic [1:0]         tx_count;
    logic [7:0]         tx_byte;
    logic               tx_dv;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (bus.i_Req_Valid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                grant_idx = PTR_W'(k);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= ST_IDLE;
            ptr       <= PTR_W'(NUM_REQ - 1);
            owner     <= '0;
            cur_rw    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            rx_data   <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            tx_count  <= 2'(BYTES_PER_XFER);
            tx_byte   <= '0;
            tx_dv     <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            tx_dv     <= 1'b0;
            tx_count  <= 2'(BYTES_PER_XFER);

            case (state)
                ST_IDLE: begin
                    if (|bus.i_Req_Valid) begin
                        req_ready <= grant;
                        ptr       <= grant_idx;
                        owner     <= grant_idx;
                        cur_rw    <= bus.i_Req_RW[grant_idx];
                        cur_addr  <= bus.i_Req_Addr[7*int'(grant_idx) +: 7];
                        cur_wdata <= bus.i_Req_WData[8*int'(grant_idx) +: 8];
                        busy      <= 1'b1;
                        state     <= ST_SEND_CMD;
                    end
                end

                // Ready may stay low through the wrapper's CS-inactive gap.
                ST_SEND_CMD: begin
                    if (bus.i_TX_Ready) begin
                        tx_dv   <= 1'b1;
                        tx_byte <= cmd_byte(cur_rw, READ_POL, cur_addr);
                        state   <= ST_GUARD;
                    end
                end

                // Wrapper ready is not yet valid in the cycle right after DV.
                ST_GUARD: begin
                    state <= ST_SEND_DATA;
                end

                ST_SEND_DATA: begin
                    if (bus.i_TX_Ready) begin
                        tx_dv   <= 1'b1;
                        tx_byte <= cur_rw ? READ_DUMMY : cur_wdata;
                        state   <= ST_WAIT_RX;
                    end
                end

                // Only the data-phase byte (index 1) carries read data.
                ST_WAIT_RX: begin
                    if (bus.i_RX_DV && (bus.i_RX_Count == 2'd1)) begin
                        rx_data <= cur_rw ? bus.i_RX_Byte : READ_DUMMY;
                        state   <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    rsp_valid <= NUM_REQ'(1) << owner;
                    rsp_rdata <= rx_data;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_Req_Ready = req_ready;
    assign bus.o_Rsp_Valid = rsp_valid;
    assign bus.o_Rsp_RData = rsp_rdata;
    assign bus.o_Busy      = busy;
    assign bus.o_TX_Count  = tx_count;
    assign bus.o_TX_Byte   = tx_byte;
    assign bus.o_TX_DV     = tx_dv;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_access_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_spi_reg_access_arbiter : directed vectors against a behavioural SPI wrapper
// Revision                  : 1.0
// ============================================================================
module tb_spi_reg_access_arbiter;

    localparam int NUM_REQ          = 2;
    localparam int CS_INACTIVE_CLKS = 4;
    localparam int SHIFT_CLKS       = 8;
    localparam int TIMEOUT          = 3000;
    localparam logic [7:0] CMD_MISO = 8'hEE;

    localparam int M_READY = 0;
    localparam int M_BUSY  = 1;
    localparam int M_STALL = 2;
    localparam int M_GAP   = 3;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    spi_reg_access_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    spi_reg_access_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .READ_POL (1'b1)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_l),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- SPI wrapper model and cycle monitor ----------------
    int         m_state      = M_READY;
    int         shift_cnt    = 0;
    int         stall_cnt    = 0;
    int         gap_cnt      = 0;
    int         byte_idx     = 0;
    int         stall_cycles = 0;
    int         since_cs_hi  = 1000;
    logic       cs_low       = 1'b0;
    logic [7:0] miso_data    = 8'h00;
    logic       prev_dv      = 1'b0;
    logic       prev_busy    = 1'b0;
    int         dv_count     = 0;
    int         rsp_count    = 0;
    logic [7:0] mosi_q[$];

    initial begin
        bus.i_TX_Ready = 1'b1;
        bus.i_RX_DV    = 1'b0;
        bus.i_RX_Byte  = 8'h00;
        bus.i_RX_Count = 2'd0;
    end

    always @(negedge clk) begin
        if (!rst_l) begin
            m_state        = M_READY;
            byte_idx       = 0;
            cs_low         = 1'b0;
            since_cs_hi    = 1000;
            prev_dv        = 1'b0;
            prev_busy      = 1'b0;
            bus.i_TX_Ready = 1'b1;
            bus.i_RX_DV    = 1'b0;
            bus.i_RX_Count = 2'd0;
        end else begin
            if (bus.o_TX_DV) begin
                check("dv_with_ready", {31'd0, bus.i_TX_Ready}, 32'd1);
                check("dv_not_consecutive", {31'd0, prev_dv}, 32'd0);
                if (byte_idx == 0)
                    check("cmd_after_cs_gap", {31'd0, since_cs_hi >= CS_INACTIVE_CLKS}, 32'd1);
                mosi_q.push_back(bus.o_TX_Byte);
                dv_count++;
            end
            if (|bus.o_Req_Ready)
                check("ready_not_while_busy", {31'd0, prev_busy}, 32'd0);
            if (|bus.o_Rsp_Valid)
                rsp_count++;
            prev_dv   = bus.o_TX_DV;
            prev_busy = bus.o_Busy;
            if (!cs_low && since_cs_hi < 1000)
                since_cs_hi++;

            bus.i_RX_DV = 1'b0;
            case (m_state)
                M_READY: begin
                    if (bus.o_TX_DV) begin
                        bus.i_TX_Ready = 1'b0;
                        cs_low         = 1'b1;
                        shift_cnt      = SHIFT_CLKS;
                        m_state        = M_BUSY;
                    end
                end
                M_BUSY: begin
                    shift_cnt--;
                    if (shift_cnt == 0) begin
                        bus.i_RX_DV    = 1'b1;
                        bus.i_RX_Count = 2'(byte_idx);
                        bus.i_RX_Byte  = (byte_idx == 0) ? CMD_MISO : miso_data;
                        if (byte_idx == 0) begin
                            byte_idx  = 1;
                            stall_cnt = stall_cycles;
                            m_state   = M_STALL;
                        end else begin
                            byte_idx    = 0;
                            cs_low      = 1'b0;
                            since_cs_hi = 0;
                            gap_cnt     = CS_INACTIVE_CLKS;
                            m_state     = M_GAP;
                        end
                    end
                end
                M_STALL: begin
                    if (stall_cnt == 0) begin
                        bus.i_TX_Ready = 1'b1;
                        m_state        = M_READY;
                    end else begin
                        stall_cnt--;
                    end
                end
                default: begin
                    gap_cnt--;
                    if (gap_cnt == 0) begin
                        stall_cnt = stall_cycles;
                        m_state   = M_STALL;
                    end
                end
            endcase
        end
    end

    // ---------------- requester helpers ----------------
    task automatic drive_req(input int k, input logic rw, input logic [6:0] addr,
                             input logic [7:0] wdata);
        bus.i_Req_RW[k]            = rw;
        bus.i_Req_Addr[7*k +: 7]   = addr;
        bus.i_Req_WData[8*k +: 8]  = wdata;
        bus.i_Req_Valid[k]         = 1'b1;
    endtask

    task automatic wait_ready(input string name, output int idx, output int cycles);
        idx    = -1;
        cycles = 0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(negedge clk);
            if (|bus.o_Req_Ready) begin
                for (int j = 0; j < NUM_REQ; j++)
                    if (bus.o_Req_Ready[j]) idx = j;
                cycles = c;
                break;
            end
        end
        if (idx < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no o_Req_Ready within %0d cycles", name, TIMEOUT);
        end
    endtask

    task automatic wait_rsp(input string name, output int idx, output logic [7:0] rdata);
        idx   = -1;
        rdata = 8'hxx;
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(negedge clk);
            if (|bus.o_Rsp_Valid) begin
                for (int j = 0; j < NUM_REQ; j++)
                    if (bus.o_Rsp_Valid[j]) idx = j;
                rdata = bus.o_Rsp_RData;
                check({name, "_busy_clear"}, {31'd0, bus.o_Busy}, 32'd0);
                break;
            end
        end
        if (idx < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no o_Rsp_Valid within %0d cycles", name, TIMEOUT);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req_ready"}, 32'(bus.o_Req_Ready), 32'd0);
        check({name, "_rsp_valid"}, 32'(bus.o_Rsp_Valid), 32'd0);
        check({name, "_rsp_rdata"}, 32'(bus.o_Rsp_RData), 32'd0);
        check({name, "_busy"},      32'(bus.o_Busy),      32'd0);
        check({name, "_tx_count"},  32'(bus.o_TX_Count),  32'd2);
        check({name, "_tx_byte"},   32'(bus.o_TX_Byte),   32'd0);
        check({name, "_tx_dv"},     32'(bus.o_TX_DV),     32'd0);
    endtask

    typedef struct {
        int         req;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] miso;
        int         stall;
        logic [7:0] exp_cmd;
        logic [7:0] exp_data;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    // ---------------- main sequence ----------------
    initial begin
        int         gidx;
        int         ridx;
        int         cyc;
        int         snap;
        logic [7:0] rd;
        logic [7:0] b0;
        logic [7:0] b1;

        vecs[0] = '{0, 1'b1, 7'h15, 8'h00, 8'h3C, 0,  8'h95, 8'h00, 8'h3C};
        vecs[1] = '{1, 1'b0, 7'h20, 8'hA5, 8'h77, 0,  8'h20, 8'hA5, 8'h00};
        vecs[2] = '{0, 1'b0, 7'h7F, 8'h01, 8'h99, 20, 8'h7F, 8'h01, 8'h00};
        vecs[3] = '{1, 1'b1, 7'h00, 8'h66, 8'hFF, 20, 8'h80, 8'h00, 8'hFF};
        vecs[4] = '{0, 1'b1, 7'h6A, 8'h12, 8'h5A, 0,  8'hEA, 8'h00, 8'h5A};

        bus.i_Req_Valid = '0;
        bus.i_Req_RW    = '0;
        bus.i_Req_Addr  = '0;
        bus.i_Req_WData = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_l = 1'b1;
        @(negedge clk);

        // Contention straight out of reset: requester 0 first, then alternate.
        miso_data = 8'h11;
        drive_req(0, 1'b1, 7'h01, 8'h00);
        drive_req(1, 1'b1, 7'h02, 8'h00);
        for (int t = 0; t < 4; t++) begin
            wait_ready("contend_grant", gidx, cyc);
            check($sformatf("contend_order_%0d", t), 32'(gidx), 32'(t % 2));
            if (t == 3) bus.i_Req_Valid = '0;
            wait_rsp("contend_rsp", ridx, rd);
            check($sformatf("contend_rsp_owner_%0d", t), 32'(ridx), 32'(t % 2));
        end
        repeat (10) @(negedge clk);

        // Table-driven single transactions.
        for (int v = 0; v < 5; v++) begin
            stall_cycles = vecs[v].stall;
            miso_data    = vecs[v].miso;
            mosi_q.delete();
            dv_count     = 0;
            drive_req(vecs[v].req, vecs[v].rw, vecs[v].addr, vecs[v].wdata);
            wait_ready("vec_grant", gidx, cyc);
            check($sformatf("vec%0d_grant", v), 32'(gidx), 32'(vecs[v].req));
            check($sformatf("vec%0d_busy", v), 32'(bus.o_Busy), 32'd1);
            bus.i_Req_Valid = '0;
            wait_rsp("vec_rsp", ridx, rd);
            check($sformatf("vec%0d_rsp_owner", v), 32'(ridx), 32'(vecs[v].req));
            check($sformatf("vec%0d_rdata", v), 32'(rd), 32'(vecs[v].exp_rdata));
            check($sformatf("vec%0d_dv_count", v), 32'(dv_count), 32'd2);
            b0 = (mosi_q.size() > 0) ? mosi_q[0] : 8'hxx;
            b1 = (mosi_q.size() > 1) ? mosi_q[1] : 8'hxx;
            check($sformatf("vec%0d_cmd_byte", v), 32'(b0), 32'(vecs[v].exp_cmd));
            check($sformatf("vec%0d_data_byte", v), 32'(b1), 32'(vecs[v].exp_data));
            @(negedge clk);
            check($sformatf("vec%0d_rsp_pulse", v), 32'(bus.o_Rsp_Valid), 32'd0);
            check($sformatf("vec%0d_rdata_hold", v), 32'(bus.o_Rsp_RData), 32'(vecs[v].exp_rdata));
            repeat (5) @(negedge clk);
        end

        // Back-to-back from the same requester.
        stall_cycles = 0;
        miso_data    = 8'h42;
        drive_req(0, 1'b1, 7'h11, 8'h00);
        wait_ready("b2b_first", gidx, cyc);
        bus.i_Req_Valid = '0;
        wait_rsp("b2b_first_rsp", ridx, rd);
        check("b2b_first_rdata", 32'(rd), 32'h42);
        mosi_q.delete();
        miso_data = 8'h43;
        drive_req(0, 1'b1, 7'h12, 8'h00);
        wait_ready("b2b_second", gidx, cyc);
        check("b2b_grant_latency", 32'(cyc), 32'd1);
        bus.i_Req_Valid = '0;
        wait_rsp("b2b_second_rsp", ridx, rd);
        b0 = (mosi_q.size() > 0) ? mosi_q[0] : 8'hxx;
        check("b2b_second_cmd", 32'(b0), 32'h92);
        check("b2b_second_rdata", 32'(rd), 32'h43);
        repeat (10) @(negedge clk);

        // Reset while waiting for the data-phase RX byte.
        dv_count = 0;
        drive_req(1, 1'b0, 7'h33, 8'h5C);
        wait_ready("rst_grant", gidx, cyc);
        bus.i_Req_Valid = '0;
        for (int c = 0; c < TIMEOUT && dv_count < 2; c++) @(negedge clk);
        check("rst_reached_wait_rx", 32'(dv_count), 32'd2);
        repeat (2) @(negedge clk);
        snap = rsp_count;
        #2 rst_l = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_no_rsp", 32'(rsp_count), 32'(snap));

        drive_req(0, 1'b1, 7'h05, 8'h00);
        drive_req(1, 1'b1, 7'h06, 8'h00);
        wait_ready("post_rst_grant", gidx, cyc);
        check("post_rst_priority", 32'(gidx), 32'd0);
        bus.i_Req_Valid[0] = 1'b0;
        wait_rsp("post_rst_rsp0", ridx, rd);
        wait_ready("post_rst_grant1", gidx, cyc);
        check("post_rst_second", 32'(gidx), 32'd1);
        bus.i_Req_Valid = '0;
        wait_rsp("post_rst_rsp1", ridx, rd);
        check("post_rst_rsp1_owner", 32'(ridx), 32'd1);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
